cmlk_3d_stream_gen: RTL and testbench
=====================================

Name: cmlk_3d_stream_gen

Overview:
- Playback transmitter for the 3D-imaging path. Reads 32-bit words from the DDR cache FIFO read port, unpacks them into channel A/B byte pairs, and drives two lock-stepped 8-bit AXI-stream masters.
- The masters feed the dual-stream (fifo a / fifo b) input of the imaging pipeline, with tlast framing.
- Used for replaying captured frames and for bench/loopback stimulus.

Parameters:
- FRAME_LEN_W, 16: width of frame_len (beats per frame).
- STARVE_CNT_W, 32: width of the starvation counter; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; starts a frame. Honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- frame_len  in  FRAME_LEN_W  beats per frame; latched on start.
- fifo_rddata  in  32  cache FIFO read data, valid 1 cycle after fifo_rden.
- fifo_rden  out  1  cache FIFO read strobe.
- fifo_empty  in  1  cache FIFO empty.
- m00_axis_tdata  out  8  channel A byte.
- m00_axis_tvalid  out  1  channel A valid.
- m00_axis_tlast  out  1  channel A last beat of frame.
- m00_axis_tready  in  1  channel A ready.
- m01_axis_tdata  out  8  channel B byte.
- m01_axis_tvalid  out  1  channel B valid.
- m01_axis_tlast  out  1  channel B last beat of frame.
- m01_axis_tready  in  1  channel B ready.
- busy  out  1  high from start until the frame is done or aborted.
- done  out  1  one-cycle pulse after the final beat's handshake.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; queue empty; counters 0.
- Word format:
  - bits [7:0] = A0, [15:8] = B0 (beat 2k).
  - bits [23:16] = A1, [31:24] = B1 (beat 2k+1).
- Words per frame = ceil(frame_len/2). For odd frame_len, the high half of the last word is discarded.
- FSM states:
  - IDLE → RUN on start with frame_len != 0. start with frame_len == 0 is ignored: no busy, no done.
  - RUN → DRAIN when the last word read has been issued.
  - DRAIN → DONE on the final beat's handshake.
  - DONE → IDLE after 1 cycle, with done = 1 in that cycle.
- Reads:
  - fifo_rden = RUN & !fifo_empty & (queue occupancy + in-flight reads < 2) & (words issued < words per frame).
  - The block never reads past the frame end and never asserts fifo_rden while fifo_empty is high.
- Queue: 2-entry word queue. Data is captured into the queue on the cycle after fifo_rden.
- Output stage (registered):
  - m00 and m01 tvalid are always equal. Both are set when a beat is available and the output register is empty or is handshaking this cycle.
  - Transfer = tvalid & m00_axis_tready & m01_axis_tready. A ready on only one channel does not advance either channel.
  - tvalid never depends on tready. tdata and tlast are stable while tvalid is high and the transfer has not completed.
- tlast: asserted on both channels on beat index frame_len-1 only.
- Latency: start at cycle T, non-empty FIFO, both readies high → fifo_rden at T+1, word captured at T+2, tvalid at T+3.
- Throughput: sustained 1 beat/cycle. A word is consumed on every second beat.
- FIFO empty mid-frame: tvalid drops after the queue drains and resumes when data arrives. No beat is lost or duplicated.
- abort:
  - In any state, next cycle: IDLE, tvalid = 0, queue flushed, busy = 0, no done pulse.
  - The read data of a read in flight at abort time is discarded.
  - abort has priority over a simultaneous start.
- start while busy: ignored.
- Beat and word counters are FRAME_LEN_W bits wide. frame_len = 2^FRAME_LEN_W - 1 must be handled without wrap.

Optional Feature:
- Macro CMLK_STREAM_GEN_STARVE_CNT_EN.
- Defined: adds output starve_cnt [STARVE_CNT_W-1:0]. It increments each RUN/DRAIN cycle in which tvalid = 0 and beats remain in the frame. It saturates at all-ones and clears on start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package cmlk_3d_imaging_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - byte-lane offset constants (A0 = 0, B0 = 8, A1 = 16, B1 = 24);
  - read-latency constant FIFO_RD_LAT = 1.
- One sub-module, cmlk_word_queue: 2-entry 32-bit queue with occupancy output and flush input.

Test Plan:
- Basic frame: frame_len = 4; FIFO words 0x44332211, 0x88776655; readies tied high → A = 11,33,55,77 and B = 22,44,66,88 on consecutive cycles; tlast on beat 3; done 1 cycle after; exactly 2 rden pulses.
- Odd length: frame_len = 3 with the same words → A = 11,33,55 and B = 22,44,66; tlast on beat 2; 2 reads; byte pair 77/88 never emitted.
- Backpressure: m01_axis_tready held low for 5 cycles mid-frame while m00 is ready → neither stream advances; tdata and tlast stable; frame completes in order.
- FIFO starvation: fifo_empty high for 10 cycles after the first word → no rden while empty; tvalid gap; no lost or duplicated beats; starve_cnt counts the gap (macro builds).
- Abort: abort at beat 2 of frame_len = 8 with a read in flight → tvalid = 0 next cycle; busy = 0; no done; a following frame_len = 2 starts clean from the next FIFO word.
- Edge cases:
  - start with frame_len = 0 → no activity.
  - rst_n asserted mid-frame → all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/cmlk_3d_imaging_pkg.sv
// Shared state type, byte-lane layout and FIFO timing for the 3D-imaging stream path.
package cmlk_3d_imaging_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

    localparam int LANE_A0 = 0;
    localparam int LANE_B0 = 8;
    localparam int LANE_A1 = 16;
    localparam int LANE_B1 = 24;

    localparam int FIFO_RD_LAT = 1;

    function automatic int unsigned words_for_beats(input int unsigned beats);
        return (beats + 1) / 2;
    endfunction

endpackage

// File: rtl/cmlk_word_queue.sv
// Two-entry fall-through word queue: an incoming word is visible at head in the
// same cycle it is pushed, so the output stage never waits an extra cycle.
module cmlk_word_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        head_vld,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count_q;
    logic        bypass;
    logic        store;
    logic        take;

    assign bypass   = (count_q == 2'd0);
    assign head     = bypass ? push_data : mem[rd_ptr];
    assign head_vld = !bypass || push;
    assign count    = count_q;

    // A word pushed and consumed in the same cycle while empty never lands in storage.
    assign store = push && !(bypass && pop);
    assign take  = pop && !bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (store) wr_ptr <= !wr_ptr;
            if (take)  rd_ptr <= !rd_ptr;
            count_q <= count_q + {1'b0, store} - {1'b0, take};
        end
    end

    always_ff @(posedge clk) begin
        if (store && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cmlk_3d_stream_gen.sv
// Cache-FIFO playback into two lock-stepped 8-bit AXI-stream masters with tlast framing.
// Optional starvation counter output enabled by `define CMLK_STREAM_GEN_STARVE_CNT_EN.
module cmlk_3d_stream_gen
    import cmlk_3d_imaging_pkg::*;
#(
    parameter int FRAME_LEN_W  = 16,
    parameter int STARVE_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic [31:0]            fifo_rddata,
    output logic                   fifo_rden,
    input  logic                   fifo_empty,
    output logic [7:0]             m00_axis_tdata,
    output logic                   m00_axis_tvalid,
    output logic                   m00_axis_tlast,
    input  logic                   m00_axis_tready,
    output logic [7:0]             m01_axis_tdata,
    output logic                   m01_axis_tvalid,
    output logic                   m01_axis_tlast,
    input  logic                   m01_axis_tready,
    output logic                   busy,
    output logic                   done
`ifdef CMLK_STREAM_GEN_STARVE_CNT_EN
    ,
    output logic [STARVE_CNT_W-1:0] starve_cnt
`endif
);

    gen_state_t             state_q, state_d;
    logic [FRAME_LEN_W-1:0] frame_len_q;
    logic [FRAME_LEN_W-1:0] words_total_q;
    logic [FRAME_LEN_W-1:0] words_issued_q;
    logic [FRAME_LEN_W-1:0] beats_loaded_q;
    logic                   half_q;
    logic [FIFO_RD_LAT-1:0] rd_vld_p1;
    logic [1:0]             inflight;
    logic [1:0]             q_count;
    logic [31:0]            q_head;
    logic                   q_head_vld;
    logic                   q_push;
    logic                   q_pop;
    logic                   active;
    logic                   xfer;
    logic                   start_ok;
    logic                   can_load;
    logic                   last_beat;
    logic                   beat_vld_p2;
    logic                   beat_last_p2;
    logic [7:0]             beat_a_p2;
    logic [7:0]             beat_b_p2;

    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign xfer      = beat_vld_p2 && m00_axis_tready && m01_axis_tready;
    assign start_ok  = (state_q == IDLE) && start && !abort && (frame_len != '0);
    assign inflight  = 2'($countones(rd_vld_p1));
    assign q_push    = rd_vld_p1[FIFO_RD_LAT-1];
    assign last_beat = (beats_loaded_q == frame_len_q - FRAME_LEN_W'(1));

    assign fifo_rden = (state_q == RUN) && !fifo_empty
                     && (({1'b0, q_count} + {1'b0, inflight}) < 3'd2)
                     && (words_issued_q < words_total_q);

    assign can_load = active && q_head_vld && (beats_loaded_q < frame_len_q)
                    && (!beat_vld_p2 || xfer);
    // The head word retires after its high half, or after its low half on an odd frame end.
    assign q_pop    = can_load && (half_q || last_beat);

    cmlk_word_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (q_push),
        .push_data (fifo_rddata),
        .pop       (q_pop),
        .head      (q_head),
        .head_vld  (q_head_vld),
        .count     (q_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (fifo_rden && (words_issued_q == words_total_q - FRAME_LEN_W'(1)))
                         state_d = DRAIN;
            DRAIN:   if (xfer && beat_last_p2) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Stage p1: control state, frame counters and read-latency tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            frame_len_q    <= '0;
            words_total_q  <= '0;
            words_issued_q <= '0;
            beats_loaded_q <= '0;
            half_q         <= 1'b0;
            rd_vld_p1      <= '0;
        end else begin
            state_q   <= state_d;
            rd_vld_p1 <= abort ? '0 : FIFO_RD_LAT'({rd_vld_p1, fifo_rden});
            if (start_ok) begin
                frame_len_q    <= frame_len;
                words_total_q  <= FRAME_LEN_W'(words_for_beats(32'(frame_len)));
                words_issued_q <= '0;
                beats_loaded_q <= '0;
                half_q         <= 1'b0;
            end else begin
                if (fifo_rden) words_issued_q <= words_issued_q + FRAME_LEN_W'(1);
                if (can_load) begin
                    beats_loaded_q <= beats_loaded_q + FRAME_LEN_W'(1);
                    half_q         <= !half_q;
                end
            end
        end
    end

    // Stage p2: registered output beat shared by both channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_vld_p2  <= 1'b0;
            beat_last_p2 <= 1'b0;
            beat_a_p2    <= '0;
            beat_b_p2    <= '0;
        end else if (abort) begin
            beat_vld_p2  <= 1'b0;
            beat_last_p2 <= 1'b0;
        end else if (can_load) begin
            beat_vld_p2  <= 1'b1;
            beat_last_p2 <= last_beat;
            beat_a_p2    <= half_q ? q_head[LANE_A1 +: 8] : q_head[LANE_A0 +: 8];
            beat_b_p2    <= half_q ? q_head[LANE_B1 +: 8] : q_head[LANE_B0 +: 8];
        end else if (xfer) begin
            beat_vld_p2  <= 1'b0;
            beat_last_p2 <= 1'b0;
        end
    end

    assign m00_axis_tdata  = beat_a_p2;
    assign m01_axis_tdata  = beat_b_p2;
    assign m00_axis_tvalid = beat_vld_p2;
    assign m01_axis_tvalid = beat_vld_p2;
    assign m00_axis_tlast  = beat_last_p2;
    assign m01_axis_tlast  = beat_last_p2;
    assign busy            = active;
    assign done            = (state_q == DONE);

`ifdef CMLK_STREAM_GEN_STARVE_CNT_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else if (start_ok) begin
            starve_cnt_q <= '0;
        end else if (active && !beat_vld_p2 && (beats_loaded_q < frame_len_q)
                     && (starve_cnt_q != '1)) begin
            starve_cnt_q <= starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    assign starve_cnt = starve_cnt_q;
`else
    logic unused_starve_w;
    assign unused_starve_w = (STARVE_CNT_W > 0);
`endif

endmodule

// File: tb/tb_cmlk_3d_stream_gen.sv
// Randomized bench for cmlk_3d_stream_gen checked against a frame-level reference model.
// Define CMLK_STREAM_GEN_STARVE_CNT_EN to also cover the starvation counter.
module tb_cmlk_3d_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] frame_len;
    logic [31:0] fifo_rddata = '0;
    logic        fifo_rden;
    logic        fifo_empty;
    logic [7:0]  a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic        a_tready, b_tready;
    logic        busy, done;
`ifdef CMLK_STREAM_GEN_STARVE_CNT_EN
    logic [31:0] starve_cnt;
`endif

    always #5 clk = ~clk;

    cmlk_3d_stream_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .frame_len       (frame_len),
        .fifo_rddata     (fifo_rddata),
        .fifo_rden       (fifo_rden),
        .fifo_empty      (fifo_empty),
        .m00_axis_tdata  (a_tdata),
        .m00_axis_tvalid (a_tvalid),
        .m00_axis_tlast  (a_tlast),
        .m00_axis_tready (a_tready),
        .m01_axis_tdata  (b_tdata),
        .m01_axis_tvalid (b_tvalid),
        .m01_axis_tlast  (b_tlast),
        .m01_axis_tready (b_tready),
        .busy            (busy),
        .done            (done)
`ifdef CMLK_STREAM_GEN_STARVE_CNT_EN
        ,
        .starve_cnt      (starve_cnt)
`endif
    );

    // Cache FIFO model: always holds data unless the bench forces starvation.
    logic [31:0] fifo_mem [65536];
    int unsigned rd_ptr = 0;
    logic        starve = 1'b0;
    assign fifo_empty = starve;

    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_rddata <= fifo_mem[rd_ptr[15:0]];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
    } beat_t;

    beat_t beats_q[$];
    beat_t prev_beat;
    int    cyc = 0;
    int    rden_cnt = 0, done_cnt = 0;
    int    first_rden = -1, first_vld = -1, last_xfer = 0, done_cyc = 0;
    int    cur_len = 0, starve_model = 0;
    logic  in_frame = 1'b0;
    logic  prev_hold = 1'b0;
    logic  x_now;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            x_now = a_tvalid && a_tready && b_tready;
            if (fifo_rden) begin
                rden_cnt++;
                chk_eq("rden_while_empty", 64'(fifo_empty), 64'd0);
                if (first_rden < 0) first_rden = cyc;
            end
            if (a_tvalid || b_tvalid) chk_eq("tvalid_pair", 64'(a_tvalid ^ b_tvalid), 64'd0);
            if (prev_hold)
                chk_eq("hold_stable", 64'({a_tvalid, b_tvalid, a_tdata, b_tdata, a_tlast}),
                       64'({2'b11, prev_beat}));
            if (a_tvalid && first_vld < 0) first_vld = cyc;
            if (in_frame && !a_tvalid && beats_q.size() < cur_len) starve_model++;
            if (x_now) begin
                chk_eq("tlast_pair", 64'(a_tlast ^ b_tlast), 64'd0);
                beats_q.push_back('{a: a_tdata, b: b_tdata, last: a_tlast});
                last_xfer = cyc;
            end
            prev_hold = a_tvalid && !x_now;
            prev_beat = '{a: a_tdata, b: b_tdata, last: a_tlast};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_frame = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        beats_q.delete();
        rden_cnt     = 0;
        done_cnt     = 0;
        first_rden   = -1;
        first_vld    = -1;
        starve_model = 0;
    endtask

    task automatic run_frame(input int len, input int rdy_pct, input int starve_pct,
                             input int gap, input int bp_at, input int bp_len,
                             input bit chk_lat, input string tag);
        int unsigned exp_ptr;
        int          start_cyc, budget, gap_left, bp_left;
        logic [31:0] w;
        beat_t       exp_b;
        exp_ptr  = rd_ptr;
        clear_mon();
        cur_len  = len;
        gap_left = gap;
        bp_left  = bp_len;
        budget   = len * 6 + 400;
        frame_len = 16'(len);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        in_frame = 1'b1;
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            if (gap_left > 0 && rden_cnt >= 1) begin
                starve = 1'b1;
                gap_left--;
            end else begin
                starve = ($urandom_range(99) < starve_pct);
            end
            if (bp_left > 0 && beats_q.size() >= bp_at) begin
                a_tready = 1'b1;
                b_tready = 1'b0;
                bp_left--;
            end else begin
                a_tready = ($urandom_range(99) < rdy_pct);
                b_tready = ($urandom_range(99) < rdy_pct);
            end
            @(posedge clk); #1;
        end
        starve   = 1'b0;
        a_tready = 1'b1;
        b_tready = 1'b1;
        in_frame = 1'b0;
        chk_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk_eq({tag, "_beat_count"}, 64'(beats_q.size()), 64'(len));
        chk_eq({tag, "_rden_count"}, 64'(rden_cnt), 64'((len + 1) / 2));
        chk_eq({tag, "_done_delay"}, 64'(done_cyc - last_xfer), 64'd1);
        for (int i = 0; i < len && i < beats_q.size(); i++) begin
            w          = fifo_mem[16'(exp_ptr + i / 2)];
            exp_b.a    = w[(i % 2) * 16 +: 8];
            exp_b.b    = w[(i % 2) * 16 + 8 +: 8];
            exp_b.last = (i == len - 1);
            chk_eq($sformatf("%s_beat%0d", tag, i), 64'(beats_q[i]), 64'(exp_b));
        end
        if (chk_lat) begin
            chk_eq({tag, "_rden_latency"}, 64'(first_rden - start_cyc), 64'd1);
            chk_eq({tag, "_tvalid_latency"}, 64'(first_vld - start_cyc), 64'd3);
            chk_eq({tag, "_throughput"}, 64'(last_xfer - first_vld), 64'(len - 1));
        end
`ifdef CMLK_STREAM_GEN_STARVE_CNT_EN
        chk_eq({tag, "_starve_cnt"}, 64'(starve_cnt), 64'(starve_model));
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) fifo_mem[i] = $urandom;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        frame_len = '0;
        a_tready  = 1'b1;
        b_tready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_outputs",
               64'({fifo_rden, a_tvalid, b_tvalid, a_tlast, b_tlast, busy, done, a_tdata, b_tdata}),
               64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        fifo_mem[16'(rd_ptr)]     = 32'h4433_2211;
        fifo_mem[16'(rd_ptr + 1)] = 32'h8877_6655;
        run_frame(4, 100, 0, 0, 0, 0, 1'b1, "basic");
        chk_eq("basic_a0", 64'(beats_q[0].a), 64'h11);
        chk_eq("basic_b3", 64'(beats_q[3].b), 64'h88);
        chk_eq("basic_last3", 64'(beats_q[3].last), 64'd1);

        fifo_mem[16'(rd_ptr)]     = 32'h4433_2211;
        fifo_mem[16'(rd_ptr + 1)] = 32'h8877_6655;
        run_frame(3, 100, 0, 0, 0, 0, 1'b1, "odd");
        chk_eq("odd_a2", 64'(beats_q[2].a), 64'h55);
        chk_eq("odd_b2", 64'(beats_q[2].b), 64'h66);

        run_frame(10, 100, 0, 0, 3, 5, 1'b0, "backpressure");
        run_frame(12, 100, 0, 10, 0, 0, 1'b0, "starve");

        // zero-length start is ignored
        clear_mon();
        frame_len = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_eq("zero_len_busy", 64'(busy), 64'd0);
        chk_eq("zero_len_rden", 64'(rden_cnt), 64'd0);
        chk_eq("zero_len_done", 64'(done_cnt), 64'd0);
        chk_eq("zero_len_tvalid", 64'(a_tvalid), 64'd0);

        // abort wins over a simultaneous start
        clear_mon();
        frame_len = 16'd5;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk_eq("abort_start_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("abort_start_rden", 64'(rden_cnt), 64'd0);

        // abort mid-frame
        clear_mon();
        frame_len = 16'd8;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && beats_q.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        chk_eq("abort_reached_beat2", 64'(beats_q.size() >= 2), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_eq("abort_tvalid", 64'(a_tvalid), 64'd0);
        chk_eq("abort_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("abort_no_done", 64'(done_cnt), 64'd0);
        chk_eq("abort_idle_tvalid", 64'(a_tvalid), 64'd0);
        run_frame(2, 100, 0, 0, 0, 0, 1'b1, "after_abort");

        // asynchronous reset mid-frame
        clear_mon();
        frame_len = 16'd20;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && beats_q.size() < 3; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_eq("async_reset_outputs",
               64'({fifo_rden, a_tvalid, b_tvalid, a_tlast, b_tlast, busy, done, a_tdata, b_tdata}),
               64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_frame(5, 100, 0, 0, 0, 0, 1'b1, "after_reset");

        for (int k = 0; k < 25; k++)
            run_frame(int'($urandom_range(24, 1)), 70, 20, 0, 0, 0, 1'b0, $sformatf("rand%0d", k));

        run_frame(65535, 100, 0, 0, 0, 0, 1'b1, "maxlen");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
